// File: rtl/ysyx_22050019_pipe_stage.sv
// ysyx_22050019_pipe_stage: two-entry skid-buffered pipeline register.
//
// The main entry drives the downstream outputs. The skid entry catches one
// beat that was accepted while main was stalled. Because in_ready comes
// straight from the skid valid flop, the backpressure path from out_ready
// to in_ready is fully registered.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high. in_valid/in_ready form the upstream side and
// out_valid/out_ready the downstream side. The producer holds its payload
// stable while valid is high and ready is low. Valid never depends
// combinationally on ready.
//
// Optional feature macro: YSYX_22050019_PIPE_DIFFTEST_EN
//   defined   : commit flag, debug sideband and stall counter are stored.
//   undefined : out_commit, out_dbg and stall_cnt are tied to 0 and have
//               no storage. Handshake and payload behaviour are identical.
module ysyx_22050019_pipe_stage #(
  parameter int DW    = 256,
  parameter int DBG_W = 352,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_commit,
  input  logic [DBG_W-1:0] in_dbg,
  input  logic             flush_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_commit,
  output logic [DBG_W-1:0] out_dbg,
  output logic [CNT_W-1:0] stall_cnt
);

  logic          main_valid;
  logic          skid_valid;
  logic [DW-1:0] main_data;
  logic [DW-1:0] skid_data;

  logic accept;
  logic main_load;
  logic main_from_skid;
  logic main_from_in;
  logic skid_from_in;
  logic main_valid_nxt;
  logic skid_valid_nxt;

  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  // Routing decisions: main reloads on handoff or when empty; skid catches a stalled accept.
  always_comb begin
    main_load      = !main_valid || out_ready;
    main_from_skid = main_load && skid_valid;
    main_from_in   = main_load && !skid_valid && accept;
    skid_from_in   = accept && (!main_load || skid_valid);
    main_valid_nxt = main_valid;
    skid_valid_nxt = skid_valid;
    if (main_load) begin
      main_valid_nxt = skid_valid || accept;
    end
    if (skid_from_in) begin
      skid_valid_nxt = 1'b1;
    end else if (main_from_skid) begin
      skid_valid_nxt = 1'b0;
    end
  end

  // Valid flags and payload storage; flush empties both entries and zeroes the payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else begin
      main_valid <= main_valid_nxt;
      skid_valid <= skid_valid_nxt;
      if (main_from_skid) begin
        main_data <= skid_data;
      end else if (main_from_in) begin
        main_data <= in_data;
      end
      if (skid_from_in) begin
        skid_data <= in_data;
      end
    end
  end

`ifdef YSYX_22050019_PIPE_DIFFTEST_EN
  logic             main_commit;
  logic             skid_commit;
  logic [DBG_W-1:0] main_dbg;
  logic [DBG_W-1:0] skid_dbg;
  logic [CNT_W-1:0] stall_q;

  // Commit flags follow the payload; flush clears them so no stale retire is reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_commit <= 1'b0;
      skid_commit <= 1'b0;
    end else if (flush_i) begin
      main_commit <= 1'b0;
      skid_commit <= 1'b0;
    end else begin
      if (main_from_skid) begin
        main_commit <= skid_commit;
      end else if (main_from_in) begin
        main_commit <= in_commit;
      end
      if (skid_from_in) begin
        skid_commit <= in_commit;
      end
    end
  end

  // Debug sideband follows the payload but survives flush for post-mortem inspection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_dbg <= '0;
      skid_dbg <= '0;
    end else if (!flush_i) begin
      if (main_from_skid) begin
        main_dbg <= skid_dbg;
      end else if (main_from_in) begin
        main_dbg <= in_dbg;
      end
      if (skid_from_in) begin
        skid_dbg <= in_dbg;
      end
    end
  end

  // Saturating count of cycles where downstream stalls a valid entry; flush does not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign out_commit = main_valid && main_commit;
  assign out_dbg    = main_dbg;
  assign stall_cnt  = stall_q;
`else
  logic unused_difftest;
  assign unused_difftest = ^{in_commit, in_dbg};

  assign out_commit = 1'b0;
  assign out_dbg    = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_ysyx_22050019_pipe_stage.sv
// Bench for ysyx_22050019_pipe_stage: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_ysyx_22050019_pipe_stage;
  localparam int DW    = 256;
  localparam int DBG_W = 352;
  localparam int CNT_W = 32;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             in_commit;
  logic [DBG_W-1:0] in_dbg;
  logic             flush_i;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             out_commit;
  logic [DBG_W-1:0] out_dbg;
  logic [CNT_W-1:0] stall_cnt;

  logic       s_in_ready;
  logic       s_out_valid;
  logic [7:0] s_out_data;
  logic       s_out_commit;
  logic [7:0] s_out_dbg;
  logic [2:0] s_stall_cnt;

  ysyx_22050019_pipe_stage #(.DW(DW), .DBG_W(DBG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_commit(in_commit), .in_dbg(in_dbg), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_commit(out_commit), .out_dbg(out_dbg), .stall_cnt(stall_cnt)
  );

  // narrow instance so the stall counter saturation is reachable
  ysyx_22050019_pipe_stage #(.DW(8), .DBG_W(8), .CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data[7:0]),
    .in_commit(in_commit), .in_dbg(in_dbg[7:0]), .flush_i(flush_i),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_commit(s_out_commit), .out_dbg(s_out_dbg), .stall_cnt(s_stall_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [DBG_W-1:0] act, input logic [DBG_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DBG_W-1:0] rnd_vec();
    logic [DBG_W-1:0] r;
    for (int i = 0; i < DBG_W; i += 32) r[i +: 32] = $urandom;
    return r;
  endfunction

  // behavioural model: FIFO of held entries, capacity two
  logic [DW-1:0]    q_data[$];
  logic             q_commit[$];
  logic [DBG_W-1:0] q_dbg[$];
  logic             m_zero;
  logic [CNT_W-1:0] m_stall;
  int               m_stall_s;
  bit               m_acc;
  bit               m_stalled;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_data.delete(); q_commit.delete(); q_dbg.delete();
      m_zero = 1'b1; m_stall = '0; m_stall_s = 0;
    end else begin
      m_acc     = in_valid && (q_data.size() < 2);
      m_stalled = (q_data.size() > 0) && !out_ready;
      if (m_stalled) begin
        if (m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1;
        if (m_stall_s < 7) m_stall_s++;
      end
      if (flush_i) begin
        q_data.delete(); q_commit.delete(); q_dbg.delete();
        m_zero = 1'b1;
      end else begin
        if ((q_data.size() > 0) && out_ready) begin
          void'(q_data.pop_front()); void'(q_commit.pop_front()); void'(q_dbg.pop_front());
        end
        if (m_acc) begin
          q_data.push_back(in_data); q_commit.push_back(in_commit); q_dbg.push_back(in_dbg);
          m_zero = 1'b0;
        end
      end
    end
  end

  // compare process: outputs against the model every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, q_data.size() < 2);
      chk("out_valid", out_valid, q_data.size() > 0);
      chk("small_out_valid", s_out_valid, q_data.size() > 0);
      if (q_data.size() > 0) begin
        chk("out_data", out_data, q_data[0]);
        chk("small_out_data", s_out_data, q_data[0][7:0]);
      end else if (m_zero) begin
        chk("out_data_zero", out_data, '0);
      end
`ifdef YSYX_22050019_PIPE_DIFFTEST_EN
      chk("out_commit", out_commit, (q_data.size() > 0) ? q_commit[0] : 1'b0);
      if (q_data.size() > 0) chk("out_dbg", out_dbg, q_dbg[0]);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("small_stall_cnt", s_stall_cnt, m_stall_s[2:0]);
`else
      chk("out_commit_off", out_commit, 1'b0);
      chk("out_dbg_off", out_dbg, '0);
      chk("stall_cnt_off", stall_cnt, '0);
      chk("small_stall_cnt_off", s_stall_cnt, '0);
`endif
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic c, input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_commit = c;
    in_dbg    = rnd_vec();
    out_ready = rdy;
    flush_i   = fl;
  endtask

  // stalls downstream and accepts 1 then 2; returns at the negedge where main=1, skid=2
  task automatic fill_two(input logic c);
    drive(1'b1, 1, c, 1'b0, 1'b0);
    @(negedge clk);
    chk("fill_in_ready_one", in_ready, 1'b1);
    drive(1'b1, 2, c, 1'b0, 1'b0);
    @(negedge clk);
    chk("fill_in_ready_full", in_ready, 1'b0);
    chk("fill_main", out_data, 1);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, '0);
    chk("rst_stall_cnt", stall_cnt, '0);
    chk("rst_out_commit", out_commit, 1'b0);
    rst_n = 1'b1;

    // single beat latency
    drive(1'b1, 'hA5, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("lat_out_valid", out_valid, 1'b1);
    chk("lat_out_data", out_data, 'hA5);
    chk("lat_in_ready", in_ready, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("lat_drained", out_valid, 1'b0);

    // skid fill then release
    fill_two(1'b1);
    @(negedge clk);
    chk("skid_hold_data", out_data, 1);
    chk("skid_hold_ready", in_ready, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("skid_second", out_data, 2);
    chk("skid_second_valid", out_valid, 1'b1);
    @(negedge clk);
    chk("skid_empty", out_valid, 1'b0);

    // skid full, release with a third beat pending
    fill_two(1'b0);
    drive(1'b1, 3, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("order_2", out_data, 2);
    chk("order_2_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("order_3", out_data, 3);
    chk("order_3_valid", out_valid, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("order_done", out_valid, 1'b0);

    // flush with both entries held
    fill_two(1'b1);
    drive(1'b1, 9, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_out_commit", out_commit, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_out_data", out_data, '0);

    // flush with a real accept in the same cycle
    drive(1'b1, 7, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("flush_acc_valid", out_valid, 1'b0);
    chk("flush_acc_ready", in_ready, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_acc_still_empty", out_valid, 1'b0);

    // stall counting and asynchronous reset mid-stall
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 'h55, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("stall_start", stall_cnt, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_data_stable", out_data, 'h55);
    end
`ifdef YSYX_22050019_PIPE_DIFFTEST_EN
    chk("stall_five", stall_cnt, 5);
`else
    chk("stall_five_off", stall_cnt, 0);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_stall", stall_cnt, '0);
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic, varying downstream pressure per phase
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 600; i++) begin
        drive($urandom_range(0, 3) != 0, DW'(rnd_vec()), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) >= ph, $urandom_range(0, 31) == 0);
        @(negedge clk);
      end
    end
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("final_empty", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22050019_pipe_stage.md
YSYX_22050019_PIPE_STAGE -- requirements
Module: ysyx_22050019_pipe_stage

Interface
REQ-001 Parameter DW, default 256: payload width in bits (ALU/mem/writeback control bundle).
REQ-002 Parameter DBG_W, default 352: debug sideband width (pc 64 + inst 32 + 4 CSR x 64).
REQ-003 Parameter CNT_W, default 32: stall-counter width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  upstream holds a valid entry.
REQ-007 in_ready  out  1  stage can accept; in_valid && in_ready is an accept.
REQ-008 in_data  in  DW  upstream payload.
REQ-009 in_commit  in  1  entry retires an instruction (difftest commit).
REQ-010 in_dbg  in  DBG_W  upstream debug sideband.
REQ-011 flush_i  in  1  kill all held entries (branch/trap redirect).
REQ-012 out_valid  out  1  downstream entry valid.
REQ-013 out_ready  in  1  downstream accepts; out_valid && out_ready is a handoff.
REQ-014 out_data  out  DW  held payload.
REQ-015 out_commit  out  1  commit flag of held entry, gated by out_valid.
REQ-016 out_dbg  out  DBG_W  held debug sideband.
REQ-017 stall_cnt  out  CNT_W  count of cycles with out_valid && !out_ready.

Function
REQ-018 The stage SHALL hold two entries: main (drives out_*) and skid; each has valid, data, commit, dbg.
REQ-019 in_ready SHALL equal !skid_valid, driven from a register only (no combinational path from out_ready).
REQ-020 On handoff or when main is empty, main SHALL load skid if skid_valid, else the accepted input, else become invalid.
REQ-021 On accept while main is valid and not handed off, the input SHALL load into skid.
REQ-022 On skid->main transfer with a simultaneous accept, the input SHALL load into skid in the same cycle.
REQ-023 Latency SHALL be 1 cycle from accept to out_valid when the stage is empty; full throughput (1 entry/cycle) with out_ready held high.
REQ-024 Entries SHALL leave in acceptance order; no entry is dropped or duplicated except by flush.
REQ-025 With out_valid && !out_ready, out_data, out_commit and out_dbg SHALL stay stable.
REQ-026 flush_i SHALL clear main and skid valid, commit and data to 0 on the next edge; dbg is not cleared.
REQ-027 Flush with a simultaneous accept: flush wins, input discarded, stage empty next cycle.
REQ-028 out_commit SHALL be 0 whenever out_valid is 0.
REQ-029 stall_cnt SHALL increment by 1 per stalled cycle, saturate at all-ones, and be unaffected by flush_i.

Reset
REQ-030 While rst_n is low, all valid and commit bits, data, dbg and stall_cnt SHALL be 0, immediately (asynchronously).
REQ-031 in_ready SHALL be 1 and out_valid 0 from reset release; reset mid-transfer discards both entries.

Configuration
REQ-032 Macro YSYX_22050019_PIPE_DIFFTEST_EN defined: dbg and commit storage and stall_cnt SHALL be implemented per REQ-015..029.
REQ-033 Macro not defined: out_dbg, out_commit and stall_cnt SHALL be constant 0 with no storage; handshake and payload behaviour SHALL be unchanged.

Verification
REQ-034 Reset release, in_valid=1 with data 0xA5 and out_ready=1 -> out_valid=1 with out_data=0xA5 one cycle later; in_ready stays 1.
REQ-035 out_ready=0, accept entries 1 then 2 -> main=1, skid=2, in_ready=0; raise out_ready -> out_data yields 1 then 2 on consecutive cycles.
REQ-036 Skid full with out_ready=1 and in_valid=1 carrying 3 -> entries 1,2,3 appear in order with no gap.
REQ-037 Both entries valid with in_commit=1, assert flush_i with in_valid=1 -> next cycle out_valid=0, out_commit=0, in_ready=1, out_data=0.
REQ-038 out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5 and out_data stable; drop rst_n mid-stall -> stall_cnt=0 and out_valid=0 immediately.
REQ-039 Build without YSYX_22050019_PIPE_DIFFTEST_EN, rerun REQ-035 -> identical out_data sequence, out_dbg=0, stall_cnt=0.
